// File: rtl/baud_ctrl_if.sv
// Baud controller handshake bundle: frame controls, generator phase
// inputs and the registered control/tick outputs.
interface baud_ctrl_if;
    logic       start;
    logic       stop;
    logic       resync;
    logic [3:0] arb_bits;
    logic [1:0] bg_cnt;
    logic       bg_inc;
    logic       bg_sync;
    logic       bg_sel;
    logic       bit_tick;
    logic       sample_tick;
    logic       busy;
    logic [1:0] state;

    modport master (
        output start, stop, resync, arb_bits, bg_cnt, bg_inc,
        input  bg_sync, bg_sel, bit_tick, sample_tick, busy, state
    );

    modport slave (
        input  start, stop, resync, arb_bits, bg_cnt, bg_inc,
        output bg_sync, bg_sel, bit_tick, sample_tick, busy, state
    );
endinterface

// File: rtl/baud_ctrl.sv
// Baud controller: low-speed arbitration bits, then switch the
// generator to the high-speed divisor until the frame ends.
module baud_ctrl (
    input  logic         clk,
    input  logic         reset,
    baud_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] arb_q, arb_d;
    logic       sync_q, sync_d;
    logic       sel_q, sel_d;
    logic       btick_q, btick_d;
    logic       stick_q, stick_d;
    logic       busy_q, busy_d;

    logic boundary;
    logic midpoint;
    logic active;
    logic switch_now;

    // Phase events are meaningless while the generator is held at zero.
    assign boundary = bus.bg_inc && (bus.bg_cnt == 2'd0) && !sync_q;
    assign midpoint = bus.bg_inc && (bus.bg_cnt == 2'd2) && !sync_q;
    assign active   = (state_q == ARB) || (state_q == DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            arb_q   <= 4'd0;
            sync_q  <= 1'b1;
            sel_q   <= 1'b0;
            btick_q <= 1'b0;
            stick_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            arb_q   <= arb_d;
            sync_q  <= sync_d;
            sel_q   <= sel_d;
            btick_q <= btick_d;
            stick_q <= stick_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arb_d   = arb_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    arb_d   = bus.arb_bits;
                    cnt_d   = 4'd0;
                    state_d = (bus.arb_bits != 4'd0) ? ARB : DATA;
                end
            end
            ARB: begin
                if (bus.stop) begin
                    state_d = TAIL;
                end else if (boundary) begin
                    if (cnt_q + 4'd1 == arb_q) begin
                        state_d = DATA;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (bus.stop) state_d = TAIL;
            end
            TAIL: begin
                if (boundary) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign switch_now = (state_q == ARB) && (state_d == DATA);

    always_comb begin
        sync_d  = (state_d == IDLE) || switch_now ||
                  (bus.resync && active && !bus.stop);
        sel_d   = sel_q;
        if (state_d == IDLE)
            sel_d = 1'b0;
        else if (state_q != DATA && state_d == DATA)
            sel_d = 1'b1;
        btick_d = boundary && (state_q != IDLE);
        stick_d = midpoint && (state_q != IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.bg_sync     = sync_q;
    assign bus.bg_sel      = sel_q;
    assign bus.bit_tick    = btick_q;
    assign bus.sample_tick = stick_q;
    assign bus.busy        = busy_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: vector table through a
// scoreboard queue, plus hand-written multi-cycle sequences.
module tb_baud_ctrl;
    logic clk = 1'b0;
    logic reset;
    baud_ctrl_if bif ();

    baud_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rst;
        logic       st;
        logic       sp;
        logic       rs;
        logic [3:0] ab;
        logic [1:0] c;
        logic       inc;
        logic [6:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [6:0] sb[$];
    int total = 0;
    int bad   = 0;
    int ticks = 0;
    int syncs = 0;

    function automatic vec_t mk(string nm, logic rst, logic st,
                                logic sp, logic rs, logic [3:0] ab,
                                logic [1:0] c, logic inc,
                                logic [6:0] exp);
        vec_t v;
        v.nm = nm; v.rst = rst; v.st = st; v.sp = sp; v.rs = rs;
        v.ab = ab; v.c = c; v.inc = inc; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {bif.bg_sync, bif.bg_sel, bif.bit_tick,
                bif.sample_tick, bif.busy, bif.state};
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(logic rst, logic st, logic sp, logic rs,
                       logic [3:0] ab, logic [1:0] c, logic inc);
        @(negedge clk);
        reset        = rst;
        bif.start    = st;
        bif.stop     = sp;
        bif.resync   = rs;
        bif.arb_bits = ab;
        bif.bg_cnt   = c;
        bif.bg_inc   = inc;
        @(posedge clk);
        #1;
        if (bif.bit_tick) ticks++;
        if (bif.bg_sync)  syncs++;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 4'd0, 2'd0, 0);
    endtask

    // Low-speed phase with bg_inc every 4 clocks (bg_cnt 1,2,3,0).
    task automatic run_arb(logic [3:0] ab, bit rsy);
        bit done = 0;
        cyc(1, 0, 0, 0, 4'd0, 2'd0, 0);
        cyc(0, 1, 0, 0, ab, 2'd0, 0);
        chk("arb_enter", {bif.bg_sync, bif.bg_sel, bif.state}, 4'b0001);
        ticks = 0;
        syncs = 0;
        for (int k = 0; k < 64; k++) begin
            cyc(0, 0, 0, 0, 4'd0, 2'((k + 1) % 4), 1);
            if (bif.state == 2'd2) break;
            if (ticks == 1 && bif.bit_tick)
                chk("sel_low_at_tick", bif.bg_sel, 0);
            if (rsy && ticks == 1 && !done) begin
                cyc(0, 0, 0, 1, 4'd0, 2'd0, 0);
                chk("resync_pulse", {bif.bg_sync, bif.state}, 3'b101);
                cyc(0, 1, 0, 0, 4'd1, 2'd0, 0);
                chk("start_in_arb", {bif.bg_sync, bif.state}, 3'b001);
                idle();
                done = 1;
            end else begin
                repeat (3) idle();
            end
        end
        chk("switch_ticks", ticks, int'(ab));
        chk("switch_syncs", syncs, 1 + int'(rsy));
        chk("switch_outs", outs(), 7'b1110110);
        idle();
        chk("post_switch", outs(), 7'b0100110);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bif.start = 0; bif.stop = 0; bif.resync = 0;
        bif.arb_bits = 0; bif.bg_cnt = 0; bif.bg_inc = 0;

        // exp = {bg_sync, bg_sel, bit_tick, sample_tick, busy, state}
        tbl.push_back(mk("rst",        1,0,0,0,0,0,0, 7'b1000000));
        tbl.push_back(mk("idle",       0,0,0,0,0,0,0, 7'b1000000));
        tbl.push_back(mk("idle_bnd",   0,0,0,0,0,0,1, 7'b1000000));
        tbl.push_back(mk("idle_mid",   0,0,0,0,0,2,1, 7'b1000000));
        tbl.push_back(mk("start_a0",   0,1,0,0,0,0,0, 7'b0100110));
        tbl.push_back(mk("d_q1",       0,0,0,0,0,1,1, 7'b0100110));
        tbl.push_back(mk("d_mid",      0,0,0,0,0,2,1, 7'b0101110));
        tbl.push_back(mk("d_bnd",      0,0,0,0,0,0,1, 7'b0110110));
        tbl.push_back(mk("d_start",    0,1,0,0,5,0,0, 7'b0100110));
        tbl.push_back(mk("d_resync",   0,0,0,1,0,0,0, 7'b1100110));
        tbl.push_back(mk("d_bnd_sync", 0,0,0,0,0,0,1, 7'b0100110));
        tbl.push_back(mk("d_stop",     0,0,1,0,0,1,1, 7'b0100111));
        tbl.push_back(mk("t_mid",      0,0,0,0,0,2,1, 7'b0101111));
        tbl.push_back(mk("t_resync",   0,0,0,1,0,0,0, 7'b0100111));
        tbl.push_back(mk("t_bnd",      0,0,0,0,0,0,1, 7'b1010000));
        tbl.push_back(mk("i_after",    0,0,0,0,0,0,0, 7'b1000000));
        tbl.push_back(mk("i_stop",     0,0,1,0,0,0,0, 7'b1000000));
        tbl.push_back(mk("start_a2",   0,1,0,0,2,0,0, 7'b0000101));
        tbl.push_back(mk("a_abchg",    0,0,0,0,0,0,0, 7'b0000101));
        tbl.push_back(mk("a_q1",       0,0,0,0,0,1,1, 7'b0000101));
        tbl.push_back(mk("a_q2",       0,0,0,0,0,2,1, 7'b0001101));
        tbl.push_back(mk("a_q3",       0,0,0,0,0,3,1, 7'b0000101));
        tbl.push_back(mk("a_bit1",     0,0,0,0,0,0,1, 7'b0010101));
        tbl.push_back(mk("a_q1b",      0,0,0,0,0,1,1, 7'b0000101));
        tbl.push_back(mk("a_q2b",      0,0,0,0,0,2,1, 7'b0001101));
        tbl.push_back(mk("a_q3b",      0,0,0,0,0,3,1, 7'b0000101));
        tbl.push_back(mk("a_switch",   0,0,0,0,0,0,1, 7'b1110110));
        tbl.push_back(mk("d_hold",     0,0,0,0,0,0,0, 7'b0100110));
        tbl.push_back(mk("d_bnd2",     0,0,0,0,0,0,1, 7'b0110110));
        tbl.push_back(mk("stop_rsync", 0,0,1,1,0,0,0, 7'b0100111));
        tbl.push_back(mk("rst_tail",   1,0,0,0,0,0,0, 7'b1000000));

        foreach (tbl[i]) begin
            sb.push_back(tbl[i].exp);
            cyc(tbl[i].rst, tbl[i].st, tbl[i].sp, tbl[i].rs,
                tbl[i].ab, tbl[i].c, tbl[i].inc);
            chk(tbl[i].nm, outs(), sb.pop_front());
        end

        run_arb(4'd2, 0);
        run_arb(4'd3, 1);

        cyc(1, 0, 0, 0, 4'd0, 2'd0, 0);
        chk("rst_in_data", outs(), 7'b1000000);

        // Stop on the would-be switching boundary.
        cyc(0, 1, 0, 0, 4'd1, 2'd0, 0);
        cyc(0, 0, 0, 0, 4'd0, 2'd1, 1);
        cyc(0, 0, 0, 0, 4'd0, 2'd2, 1);
        cyc(0, 0, 0, 0, 4'd0, 2'd3, 1);
        syncs = 0;
        cyc(0, 0, 1, 0, 4'd0, 2'd0, 1);
        chk("stop_on_switch", outs(), 7'b0010111);
        chk("stop_sw_nosync", syncs, 0);
        cyc(0, 0, 0, 0, 4'd0, 2'd1, 1);
        cyc(0, 0, 0, 0, 4'd0, 2'd2, 1);
        cyc(0, 0, 0, 0, 4'd0, 2'd3, 1);
        chk("tail_wait", outs(), 7'b0000111);
        cyc(0, 0, 0, 0, 4'd0, 2'd0, 1);
        chk("tail_exit", outs(), 7'b1010000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/baud_ctrl.md
BAUD_CTRL -- requirements
Module: baud_ctrl

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 start  in  1  one-cycle pulse, begin frame; honoured in IDLE only.
REQ-005 stop  in  1  one-cycle pulse, end frame; honoured in ARB/DATA only.
REQ-006 resync  in  1  line-edge pulse; realigns bit phase in ARB/DATA.
REQ-007 arb_bits  in  4  low-speed bit count before rate switch, 0..15; latched on accepted start.
REQ-008 bg_cnt  in  2  quarter-bit phase from baud generator.
REQ-009 bg_inc  in  1  quarter-bit strobe from baud generator; bg_cnt already holds the new value when high.
REQ-010 bg_sync  out  1  registered; holds generator counters at zero.
REQ-011 bg_sel  out  1  registered; 0 = low-speed divisor, 1 = high-speed divisor.
REQ-012 bit_tick  out  1  registered one-cycle pulse at each completed bit.
REQ-013 sample_tick  out  1  registered one-cycle pulse at mid-bit sample point.
REQ-014 busy  out  1  registered; high in ARB, DATA, TAIL.
REQ-015 state  out  2  IDLE=0, ARB=1, DATA=2, TAIL=3.

Function
REQ-016 boundary = bg_inc && bg_cnt==0; midpoint = bg_inc && bg_cnt==2, both evaluated on inputs; bit_tick/sample_tick SHALL follow one cycle later, only when state!=IDLE.
REQ-017 IDLE: bg_sync=1, bg_sel=0, busy=0; on start -> ARB if arb_bits!=0, else DATA with bg_sel=1; bg_sync=0 from the next cycle.
REQ-018 ARB: 4-bit bit_cnt starts at 0, increments per boundary; when boundary occurs with bit_cnt+1==latched arb_bits -> DATA, bg_sel=1, bg_sync=1 for exactly one cycle, bit_cnt cleared.
REQ-019 DATA: bg_sel=1 held; remain until stop.
REQ-020 stop in ARB or DATA -> TAIL; bg_sel unchanged.
REQ-021 TAIL: wait for next boundary; on it, bit_tick still emitted, then -> IDLE (bg_sync=1, bg_sel=0 next cycle).
REQ-022 resync in ARB/DATA: bg_sync=1 for one cycle; bit_cnt and state unchanged; ignored in IDLE and TAIL.
REQ-023 Priority, same cycle: reset > stop > rate switch > resync; stop with switch-boundary -> TAIL, bg_sel unchanged; resync with switch -> single bg_sync pulse.
REQ-024 start outside IDLE SHALL be ignored; arb_bits changes after latch SHALL have no effect.
REQ-025 bg_sel SHALL change only on IDLE->DATA, ARB->DATA, or TAIL->IDLE transitions.
REQ-026 Boundary/midpoint during a bg_sync=1 cycle SHALL be ignored.

Reset
REQ-027 On reset: state=IDLE, bg_sync=1, bg_sel=0, bit_tick=0, sample_tick=0, busy=0, bit_cnt=0, latched arb_bits=0.
REQ-028 reset mid-frame SHALL abort immediately; pending TAIL/switch discarded.

Verification
REQ-029 arb_bits=2, start, bench drives bg_inc every 4 clk with bg_cnt 1,2,3,0 -> 2 bit_ticks with bg_sel=0, then bg_sync 1-cycle pulse, bg_sel=1, state=DATA.
REQ-030 arb_bits=0, start -> next cycle state=DATA, bg_sel=1, bg_sync=0, busy=1.
REQ-031 In DATA, stop at bg_cnt=1 -> state=TAIL, next bg_cnt=0 boundary gives bit_tick, then state=IDLE, bg_sync=1, bg_sel=0.
REQ-032 resync in ARB after 1 bit (arb_bits=3) -> one bg_sync pulse, switch still after 3rd bit_tick total.
REQ-033 stop coincident with switching boundary (arb_bits=1) -> TAIL, bg_sel stays 0, no bg_sync pulse.
REQ-034 reset asserted in DATA -> next cycle all outputs at REQ-027 values; start in ARB ignored (bit_cnt unchanged).
